jam_cost_server: RTL
====================

// Module: jam_cost_server
// PURPOSE
//  Responder side of the JAM cost-lookup interface. Holds an 8x8 worker/job cost table and
//  answers the solver's (W,J) address with Cost in the same cycle.
//  Captures the solver's MatchCount/MinCost on Valid and checks them against expected values.
//  Sits opposite the JAM solver in the contest harness and in the FPGA self-test wrapper.
// PARAMETERS
//  N           8        workers = jobs; table is N x N
//  CW          7        cost entry width
//  SW          10       MinCost width (sum of N entries)
//  MCW         4        MatchCount width
//  CYCW        20       cycle-counter width
//  TIMEOUT_CYC 1000000  watchdog limit in cycles; used only with JAM_TIMEOUT_EN
// PORTS
//  CLK          in   1    clock, rising edge
//  RST_N        in   1    asynchronous reset, active low
//  LD_VALID     in   1    load beat valid
//  LD_READY     out  1    server accepts a load beat
//  LD_DATA      in   CW   cost entry, row-major: beat k -> W=k/N, J=k%N
//  W            in   3    worker address from solver
//  J            in   3    job address from solver
//  Cost         out  CW   table[W][J]
//  Valid        in   1    solver result strobe
//  MatchCount   in   MCW  solver match count
//  MinCost      in   SW   solver minimum cost
//  EXP_COUNT    in   MCW  expected match count; static while SERVE
//  EXP_COST     in   SW   expected minimum cost; static while SERVE
//  DONE         out  1    result captured or timed out; sticky until reset
//  PASS         out  1    captured result equals expected; qualified by DONE
//  RES_COUNT    out  MCW  captured MatchCount
//  RES_COST     out  SW   captured MinCost
//  CYCLES       out  CYCW SERVE cycles up to and including the Valid cycle; saturates at all-ones
//  TIMEOUT      out  1    watchdog fired; only with JAM_TIMEOUT_EN
// BEHAVIOUR
//  Reset (RST_N=0, async): state=LOAD, table cleared to 0, beat count=0.
//   All outputs 0 except LD_READY=1.
//  FSM LOAD->SERVE->DONE; DONE is terminal. Only reset leaves DONE.
//  LOAD:
//   - LD_READY=1. On LD_VALID&LD_READY, write LD_DATA to entry (k/N, k%N), then k++.
//   - The write on beat N*N-1 (63) moves to SERVE the next cycle; LD_READY drops in that cycle.
//   - Cost=0. Valid is ignored.
//  SERVE:
//   - Cost = table[W][J], combinational, zero latency, so the solver samples it in the same cycle.
//   - CYCLES increments every SERVE cycle.
//   - First cycle with Valid=1: register MatchCount->RES_COUNT and MinCost->RES_COST.
//     PASS=(MatchCount==EXP_COUNT)&&(MinCost==EXP_COST). DONE=1 from the next cycle.
//   - Valid in the first SERVE cycle is accepted.
//  DONE:
//   - Cost=0, LD_READY=0.
//   - Further Valid pulses and LD_VALID are ignored. Result outputs hold.
//  Boundaries:
//   - LD_VALID while LD_READY=0: no write.
//   - W/J are always in range (3 bits, N=8).
//   - CYCLES saturates, never wraps.
//   - Reset mid-LOAD or mid-SERVE discards all entries and any partial result.
// CONFIGURATION
//  JAM_TIMEOUT_EN defined:
//   - If CYCLES reaches TIMEOUT_CYC in SERVE without Valid: TIMEOUT=1, DONE=1, PASS=0, go to DONE.
//   - Valid in that same cycle wins: normal capture, TIMEOUT=0.
//  JAM_TIMEOUT_EN undefined:
//   - No watchdog logic. TIMEOUT is tied 0. SERVE waits indefinitely for Valid.
// STRUCTURE
//  jam_pkg holds:
//   - N, CW, SW, MCW defaults
//   - state enum {ST_LOAD, ST_SERVE, ST_DONE}
//   - the row-major index helper
//  Sub-module jam_cost_ram: N x N CW-bit register array.
//   - One synchronous write port (wr_en, wr_w, wr_j, wr_data) and one combinational read port.
//   - Async clear on RST_N.
//  Top holds the FSM, beat counter, cycle counter, result capture and the watchdog.
// TESTING
//  1 Load entries 0..63 with value=k; W=3,J=5 in SERVE -> Cost=29 in the same cycle.
//  2 Valid with MatchCount=2, MinCost=24, EXP=(2,24) -> next cycle DONE=1, PASS=1, RES=(2,24).
//  3 Valid with MinCost=25 vs EXP_COST=24 -> DONE=1, PASS=0.
//    A second Valid with MinCost=24 leaves RES_COST=25.
//  4 Drop LD_VALID for 5 cycles mid-load (after beat 20) -> no writes, LD_READY stays 1.
//    Loading resumes at beat 21, and table contents are correct.
//  5 Assert RST_N=0 mid-SERVE -> immediately LD_READY=1, Cost=0, DONE=0.
//    After reload, the table holds only the new data.
//  6 With JAM_TIMEOUT_EN and TIMEOUT_CYC=100, no Valid -> TIMEOUT=1, DONE=1, PASS=0 after CYCLES=100.

Source files
------------

// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared sizes, FSM states and row-major index helper for the JAM cost server
package jam_pkg;

    localparam int N    = 8;
    localparam int CW   = 7;
    localparam int SW   = 10;
    localparam int MCW  = 4;
    localparam int IDXW = $clog2(N * N);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SERVE,
        ST_DONE
    } jam_state_e;

    function automatic logic [IDXW-1:0] jam_idx(input logic [2:0] w, input logic [2:0] j);
        return IDXW'(int'(w) * N + int'(j));
    endfunction

endpackage

// File: rtl/jam_cost_ram.sv
// rtl/jam_cost_ram.sv - N x N cost table, one synchronous write port, one combinational read port
module jam_cost_ram
    import jam_pkg::*;
#(
    parameter int DW = CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [2:0]    wr_w,
    input  logic [2:0]    wr_j,
    input  logic [DW-1:0] wr_data,
    input  logic [2:0]    rd_w,
    input  logic [2:0]    rd_j,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [N*N];
    logic [DW-1:0] mem_d [N*N];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[jam_idx(wr_w, wr_j)] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N * N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[jam_idx(rd_w, rd_j)];

endmodule

// File: rtl/jam_cost_server.sv
// rtl/jam_cost_server.sv - JAM cost-lookup responder: table load, zero-latency serve, result check
module jam_cost_server
    import jam_pkg::*;
#(
    parameter int CYCW        = 20,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            LD_VALID,
    output logic            LD_READY,
    input  logic [CW-1:0]   LD_DATA,
    input  logic [2:0]      W,
    input  logic [2:0]      J,
    output logic [CW-1:0]   Cost,
    input  logic            Valid,
    input  logic [MCW-1:0]  MatchCount,
    input  logic [SW-1:0]   MinCost,
    input  logic [MCW-1:0]  EXP_COUNT,
    input  logic [SW-1:0]   EXP_COST,
    output logic            DONE,
    output logic            PASS,
    output logic [MCW-1:0]  RES_COUNT,
    output logic [SW-1:0]   RES_COST,
    output logic [CYCW-1:0] CYCLES,
    output logic            TIMEOUT
);

    localparam logic [IDXW-1:0] LAST_BEAT = IDXW'(N * N - 1);

    jam_state_e      state_q, state_d;
    logic [IDXW-1:0] beat_q, beat_d;
    logic [CYCW-1:0] cycles_q, cycles_d, cycles_inc;
    logic [MCW-1:0]  res_count_q, res_count_d;
    logic [SW-1:0]   res_cost_q, res_cost_d;
    logic            pass_q, pass_d;
    logic            wr_en;
    logic [2:0]      wr_w, wr_j;
    logic [CW-1:0]   rd_data;

`ifdef JAM_TIMEOUT_EN
    localparam logic [CYCW-1:0] TIMEOUT_LIM = CYCW'(TIMEOUT_CYC);
    logic timeout_q, timeout_d;
`endif

    assign wr_w = 3'(int'(beat_q) / N);
    assign wr_j = 3'(int'(beat_q) % N);

    jam_cost_ram #(.DW(CW)) u_ram (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (wr_en),
        .wr_w    (wr_w),
        .wr_j    (wr_j),
        .wr_data (LD_DATA),
        .rd_w    (W),
        .rd_j    (J),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cycles_d    = cycles_q;
        res_count_d = res_count_q;
        res_cost_d  = res_cost_q;
        pass_d      = pass_q;
        wr_en       = 1'b0;
`ifdef JAM_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        cycles_inc  = (&cycles_q) ? cycles_q : cycles_q + CYCW'(1);

        unique case (state_q)
            ST_LOAD: begin
                if (LD_VALID) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + IDXW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                cycles_d = cycles_inc;
                if (Valid) begin
                    res_count_d = MatchCount;
                    res_cost_d  = MinCost;
                    pass_d      = (MatchCount == EXP_COUNT) && (MinCost == EXP_COST);
                    state_d     = ST_DONE;
                end
`ifdef JAM_TIMEOUT_EN
                else if (cycles_inc == TIMEOUT_LIM) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = ST_DONE;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_LOAD;
            beat_q      <= '0;
            cycles_q    <= '0;
            res_count_q <= '0;
            res_cost_q  <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cycles_q    <= cycles_d;
            res_count_q <= res_count_d;
            res_cost_q  <= res_cost_d;
            pass_q      <= pass_d;
        end
    end

`ifdef JAM_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign LD_READY  = (state_q == ST_LOAD);
    assign DONE      = (state_q == ST_DONE);
    assign PASS      = pass_q;
    assign RES_COUNT = res_count_q;
    assign RES_COST  = res_cost_q;
    assign CYCLES    = cycles_q;
    assign Cost      = (state_q == ST_SERVE) ? rd_data : '0;

endmodule
